// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: packs PPB RGB pixels per AXI-Stream beat. A line end
// flushes a partial beat with its unused lanes masked in tkeep. Completed beats
// wait in a DEPTH-entry FIFO, so the pixel source can keep pushing one pixel
// per cycle while the downstream DMA applies backpressure.
module pixel_stream_packer #(
  parameter int PPB   = 2,
  parameter int DEPTH = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [7:0]           r,
  input  logic [7:0]           g,
  input  logic [7:0]           b,
  input  logic                 valid,
  input  logic                 sof,
  input  logic                 eol,
  output logic                 in_stream_ready,
  output logic [32*PPB-1:0]    out_stream_tdata,
  output logic [4*PPB-1:0]     out_stream_tkeep,
  output logic                 out_stream_tlast,
  output logic                 out_stream_tuser,
  output logic                 out_stream_tvalid,
  input  logic                 out_stream_tready,
  output logic                 resync_drop
);

  localparam int LANE_W = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPB - 1);

  typedef struct packed {
    logic [32*PPB-1:0] data;
    logic [4*PPB-1:0]  keep;
    logic              last;
    logic              user;
  } beat_t;

  // Accumulator for the beat currently being built
  logic [32*PPB-1:0] acc_data_q, acc_data_d;
  logic              acc_user_q, acc_user_d;
  logic [LANE_W-1:0] lane_idx_q, lane_idx_d;
  logic              resync_drop_q, resync_drop_d;

  // Completed-beat FIFO
  beat_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              input_fire;
  logic              push;
  logic              pop;
  beat_t             push_beat;
  beat_t             head;

  // Working values for the pixel accepted this cycle
  logic [LANE_W-1:0] eff_lane;
  logic [32*PPB-1:0] base_data;
  logic              base_user;
  logic [32*PPB-1:0] new_data;
  logic              new_user;

  // Ready depends only on FIFO occupancy, never on tready in the same cycle
  assign in_stream_ready = (count_q != CNT_W'(DEPTH));
  assign input_fire      = valid && in_stream_ready;
  assign pop             = (count_q != '0) && out_stream_tready;

  // Place the incoming pixel into its lane and decide whether the beat closes
  always_comb begin
    // NOTE: every variable written in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    acc_data_d    = acc_data_q;
    acc_user_d    = acc_user_q;
    lane_idx_d    = lane_idx_q;
    resync_drop_d = 1'b0;
    push          = 1'b0;
    push_beat     = '0;
    eff_lane      = lane_idx_q;
    base_data     = acc_data_q;
    base_user     = acc_user_q;
    new_data      = '0;
    new_user      = 1'b0;

    if (input_fire) begin
      // A frame start in the middle of a beat means the previous line lost its
      // eol; throw the partial beat away and restart at lane 0.
      if (sof && (lane_idx_q != '0)) begin
        resync_drop_d = 1'b1;
        eff_lane      = '0;
        base_data     = '0;
        base_user     = 1'b0;
      end

      new_data = base_data;
      for (int k = 0; k < PPB; k++) begin
        if (LANE_W'(k) == eff_lane) new_data[32*k +: 32] = {8'h00, r, g, b};
      end
      new_user = base_user | sof;

      if ((eff_lane == LAST_LANE) || eol) begin
        push           = 1'b1;
        push_beat.data = new_data;
        for (int k = 0; k < PPB; k++) begin
          push_beat.keep[4*k +: 4] = (LANE_W'(k) <= eff_lane) ? 4'hF : 4'h0;
        end
        push_beat.last = eol;
        push_beat.user = new_user;
        acc_data_d     = '0;
        acc_user_d     = 1'b0;
        lane_idx_d     = '0;
      end else begin
        acc_data_d = new_data;
        acc_user_d = new_user;
        lane_idx_d = eff_lane + 1'b1;
      end
    end
  end

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control and accumulator state
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!aresetn) begin
      acc_data_q    <= '0;
      acc_user_q    <= 1'b0;
      lane_idx_q    <= '0;
      resync_drop_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      acc_data_q    <= acc_data_d;
      acc_user_q    <= acc_user_d;
      lane_idx_q    <= lane_idx_d;
      resync_drop_q <= resync_drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage write
  always_ff @(posedge aclk) begin
    // NOTE: the storage array has no reset; the output mux below forces zeros
    // whenever the FIFO is empty, so stale contents are never visible.
    if (push) mem_q[wr_ptr_q] <= push_beat;
  end

  // Present the FIFO head, zeroed when nothing is stored
  always_comb begin
    head              = mem_q[rd_ptr_q];
    out_stream_tvalid = (count_q != '0);
    out_stream_tdata  = out_stream_tvalid ? head.data : '0;
    out_stream_tkeep  = out_stream_tvalid ? head.keep : '0;
    out_stream_tlast  = out_stream_tvalid && head.last;
    out_stream_tuser  = out_stream_tvalid && head.user;
  end

  assign resync_drop = resync_drop_q;

endmodule
